// File: rtl/safecrack_param.sv
// Parametrised safe-lock controller: code programming, per-digit entry with
// LED feedback, a retry budget, escalating lockout and a mid-entry timeout.
module safecrack_param #(
  parameter int N_DIGITS     = 4,
  parameter int N_BTN        = 4,
  parameter int MAX_FAILS    = 3,
  parameter int MAX_ESC      = 3,
  parameter int FEEDBACK_CYC = 25_000_000,
  parameter int LOCK_CYC     = 500_000_000,
  parameter int BLINK_CYC    = 5_000_000,
  parameter int TIMEOUT_CYC  = 250_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             confirm,
  input  logic [N_BTN-1:0] btn_n,
  output logic             led_green,
  output logic             led_red,
  output logic [2:0]       digit_idx,
  output logic [3:0]       fails_left,
  output logic             locked,
  output logic             code_set
);

  localparam int DW  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW  = $clog2(N_DIGITS + 1);
  localparam int FW  = $clog2(MAX_FAILS + 1);
  localparam int EW  = (MAX_ESC > 0) ? $clog2(MAX_ESC + 1) : 1;
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [39:0]    FB_LOAD    = 40'(FEEDBACK_CYC);
  localparam logic [39:0]    LOCK_BASE  = 40'(LOCK_CYC);
  localparam logic [FW-1:0]  FAILS_INIT = FW'(MAX_FAILS);
  localparam logic [EW-1:0]  ESC_MAX    = EW'(MAX_ESC);
  localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [BW-1:0]  BLINK_HALF = BW'(BLINK_CYC / 2);
  localparam logic [CW-1:0]  CNT_FULL   = CW'(N_DIGITS);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, PROGRAM, INPUT, FEEDBACK, CHECK, RETRY, UNLOCKED, LOCKED
  } state_t;

  // Input synchronisers; the third stage holds the previous synchronised value for edge detection
  logic [N_BTN-1:0] btn_s1_reg, btn_s2_reg, btn_prev_reg;
  logic             conf_s1_reg, conf_s2_reg, conf_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_reg    <= '1;
      btn_s2_reg    <= '1;
      btn_prev_reg  <= '1;
      conf_s1_reg   <= 1'b0;
      conf_s2_reg   <= 1'b0;
      conf_prev_reg <= 1'b0;
    end else begin
      btn_s1_reg    <= btn_n;
      btn_s2_reg    <= btn_s1_reg;
      btn_prev_reg  <= btn_s2_reg;
      conf_s1_reg   <= confirm;
      conf_s2_reg   <= conf_s1_reg;
      conf_prev_reg <= conf_s2_reg;
    end
  end

  logic             conf_fall;
  logic [N_BTN-1:0] press_vec;
  logic             press;
  logic [DW-1:0]    press_digit;

  assign conf_fall = conf_prev_reg & ~conf_s2_reg;
  assign press_vec = btn_prev_reg & ~btn_s2_reg;

  // Descending scan so the lowest pressed index is the one left standing
  always_comb begin
    press       = 1'b0;
    press_digit = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_vec[i]) begin
        press       = 1'b1;
        press_digit = DW'(i);
      end
    end
  end

  logic [BW-1:0] blink_reg;
  logic          blink_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       blink_reg <= '0;
    else if (blink_reg == BLINK_LAST) blink_reg <= '0;
    else                           blink_reg <= blink_reg + BW'(1);
  end

  assign blink_on = (blink_reg >= BLINK_HALF);

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [CW-1:0]   prog_cnt_reg, prog_cnt_next;
  logic [FW-1:0]   fails_reg, fails_next;
  logic [EW-1:0]   esc_reg, esc_next;
  logic [39:0]     timer_reg, timer_next;
  logic [TOW-1:0]  idle_reg, idle_next;
  logic            correct_reg, correct_next;
  logic            code_set_reg, code_set_next;
  logic            led_green_reg, led_green_next;
  logic            led_red_reg, led_red_next;
  logic            code_we, att_we;
  logic            timer_done;

  logic [DW-1:0]       code_reg [N_DIGITS];
  logic [DW-1:0]       att_reg  [N_DIGITS];
  logic [N_DIGITS-1:0] digit_ok;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_match
    assign digit_ok[gi] = (att_reg[gi] == code_reg[gi]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        code_reg[i] <= '0;
        att_reg[i]  <= '0;
      end
    end else begin
      if (code_we) code_reg[prog_cnt_reg[IW-1:0]] <= press_digit;
      if (att_we)  att_reg[idx_reg] <= press_digit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      prog_cnt_reg  <= '0;
      fails_reg     <= FAILS_INIT;
      esc_reg       <= '0;
      timer_reg     <= '0;
      idle_reg      <= '0;
      correct_reg   <= 1'b0;
      code_set_reg  <= 1'b0;
      led_green_reg <= 1'b0;
      led_red_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      prog_cnt_reg  <= prog_cnt_next;
      fails_reg     <= fails_next;
      esc_reg       <= esc_next;
      timer_reg     <= timer_next;
      idle_reg      <= idle_next;
      correct_reg   <= correct_next;
      code_set_reg  <= code_set_next;
      led_green_reg <= led_green_next;
      led_red_reg   <= led_red_next;
    end
  end

  assign timer_done = (timer_reg <= 40'd1);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    prog_cnt_next = prog_cnt_reg;
    fails_next    = fails_reg;
    esc_next      = esc_reg;
    timer_next    = timer_reg;
    idle_next     = idle_reg;
    correct_next  = correct_reg;
    code_set_next = code_set_reg;
    code_we       = 1'b0;
    att_we        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (conf_s2_reg) begin
          state_next = PROGRAM;
        end else if (code_set_reg) begin
          state_next = INPUT;
          idx_next   = '0;
        end
      end
      PROGRAM: begin
        if (conf_fall) begin
          state_next    = IDLE;
          code_set_next = (prog_cnt_reg == CNT_FULL);
        end else if (press && (prog_cnt_reg != CNT_FULL)) begin
          code_we       = 1'b1;
          prog_cnt_next = prog_cnt_reg + CW'(1);
        end
      end
      INPUT: begin
        if (press) begin
          att_we       = 1'b1;
          correct_next = (press_digit == code_reg[idx_reg]);
          timer_next   = FB_LOAD;
          state_next   = FEEDBACK;
        end else if (idx_reg != '0) begin
          // A stalled partial entry is thrown away without costing an attempt
          if (idle_reg == TO_LAST) begin
            idx_next  = '0;
            idle_next = '0;
          end else begin
            idle_next = idle_reg + TOW'(1);
          end
        end
      end
      FEEDBACK: begin
        if (timer_done) begin
          timer_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = CHECK;
          end else begin
            idx_next   = idx_reg + IW'(1);
            state_next = INPUT;
          end
        end else begin
          timer_next = timer_reg - 40'd1;
        end
      end
      CHECK: begin
        if (&digit_ok) begin
          state_next = UNLOCKED;
          fails_next = FAILS_INIT;
          esc_next   = '0;
        end else if (fails_reg <= FW'(1)) begin
          fails_next = '0;
          state_next = LOCKED;
          timer_next = LOCK_BASE << esc_reg;
        end else begin
          fails_next = fails_reg - FW'(1);
          state_next = RETRY;
          timer_next = FB_LOAD;
        end
      end
      RETRY: begin
        if (timer_done) begin
          timer_next = '0;
          idx_next   = '0;
          state_next = INPUT;
        end else begin
          timer_next = timer_reg - 40'd1;
        end
      end
      UNLOCKED: begin
        if (conf_s2_reg) state_next = PROGRAM;
      end
      LOCKED: begin
        if (timer_done) begin
          timer_next = '0;
          esc_next   = (esc_reg >= ESC_MAX) ? esc_reg : esc_reg + EW'(1);
          fails_next = FAILS_INIT;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 40'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Entry actions shared by every path into PROGRAM and INPUT
    if ((state_next == PROGRAM) && (state_reg != PROGRAM)) begin
      code_set_next = 1'b0;
      prog_cnt_next = '0;
      fails_next    = FAILS_INIT;
      esc_next      = '0;
    end
    if ((state_next == INPUT) && (state_reg != INPUT)) begin
      idle_next = '0;
    end
  end

  always_comb begin
    led_green_next = (state_reg == UNLOCKED) ||
                     ((state_reg == FEEDBACK) && correct_reg && blink_on);
    led_red_next   = (state_reg == LOCKED) || ((state_reg == RETRY) && blink_on);
  end

  assign led_green  = led_green_reg;
  assign led_red    = led_red_reg;
  assign digit_idx  = 3'(idx_reg);
  assign fails_left = 4'(fails_reg);
  assign locked     = (state_reg == LOCKED);
  assign code_set   = code_set_reg;

endmodule

// File: tb/tb_safecrack_param.sv
// Directed bench for safecrack_param with short timing parameters.
`timescale 1ns/1ps
module tb_safecrack_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       confirm;
  logic [3:0] btn_n;
  logic       led_green, led_red, locked, code_set;
  logic [2:0] digit_idx;
  logic [3:0] fails_left;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  safecrack_param #(
    .N_DIGITS(4), .N_BTN(4), .MAX_FAILS(2), .MAX_ESC(3),
    .FEEDBACK_CYC(8), .LOCK_CYC(32), .BLINK_CYC(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .confirm(confirm), .btn_n(btn_n),
    .led_green(led_green), .led_red(led_red), .digit_idx(digit_idx),
    .fails_left(fails_left), .locked(locked), .code_set(code_set)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit hit, got no finish, want finish");
    $fatal(1, "time limit");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_raw(input logic [3:0] mask);
    btn_n = ~mask;
    wait_neg(2);
    btn_n = 4'hF;
    wait_neg(3);
  endtask

  task automatic program_code(input int d0, input int d1, input int d2, input int d3,
                              input int n, input logic [3:0] extra0, output logic cs_mid);
    int ds [4];
    ds = '{d0, d1, d2, d3};
    confirm = 1'b1;
    wait_neg(4);
    cs_mid = code_set;
    for (int i = 0; i < n; i++) press_raw(4'(1 << ds[i]) | ((i == 0) ? extra0 : 4'h0));
    confirm = 1'b0;
    wait_neg(5);
    $display("[tb] program %0d digits (%0d %0d %0d %0d): code_set=%0d", n, d0, d1, d2, d3, code_set);
  endtask

  // Presses one digit and counts green cycles over the whole feedback window.
  task automatic enter_digit(input int d, output int on_cnt);
    on_cnt = 0;
    btn_n[d] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) btn_n = 4'hF;
      if (led_green === 1'b1) on_cnt++;
    end
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3,
                            output logic [15:0] cnts);
    int ds [4];
    int c;
    ds = '{d0, d1, d2, d3};
    cnts = '0;
    for (int i = 0; i < 4; i++) begin
      enter_digit(ds[i], c);
      cnts[4*i +: 4] = 4'(c);
    end
    $display("[tb] enter %0d %0d %0d %0d: green counts=%h fails_left=%0d", d0, d1, d2, d3, cnts, fails_left);
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    exp_v = {1'b0, 1'b0, 3'd0, 4'd2, 1'b0, 1'b0};
    rst = 1'b1; confirm = 1'b0; btn_n = 4'hF;
    wait_neg(3);
    n_cmp++;
    if ({led_green, led_red, digit_idx, fails_left, locked, code_set} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", {led_green, led_red, digit_idx, fails_left, locked, code_set}, exp_v);
    end
    rst = 1'b0;
    wait_neg(3);
    n_cmp++;
    if ({led_green, led_red, digit_idx, fails_left, locked, code_set} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", {led_green, led_red, digit_idx, fails_left, locked, code_set}, exp_v);
    end
    $display("[tb] test_reset done");
  endtask

  task automatic test_program_short();
    logic cs_mid;
    int c;
    program_code(2, 0, 0, 0, 2, 4'h0, cs_mid);
    n_cmp++;
    if (code_set !== 1'b0) begin
      n_bad++; $display("FAIL short_code_set: got %0d want 0", code_set);
    end
    enter_digit(3, c);
    n_cmp++;
    if (c !== 0 || digit_idx !== 3'd0) begin
      n_bad++; $display("FAIL idle_press_ignored: got green=%0d idx=%0d want 0 0", c, digit_idx);
    end
  endtask

  task automatic test_program_full();
    logic cs_mid;
    program_code(3, 1, 0, 2, 4, 4'h0, cs_mid);
    n_cmp++;
    if (code_set !== 1'b1) begin
      n_bad++; $display("FAIL full_code_set: got %0d want 1", code_set);
    end
  endtask

  task automatic test_unlock();
    logic [15:0] cnts;
    int g;
    enter_code(3, 1, 0, 2, cnts);
    n_cmp++;
    if (cnts !== 16'h4444) begin
      n_bad++; $display("FAIL unlock_digit_blink: got %h want 4444", cnts);
    end
    g = 0;
    wait_neg(1);
    for (int k = 0; k < 10; k++) begin
      wait_neg(1);
      if (led_green === 1'b1) g++;
    end
    n_cmp++;
    if (g !== 10) begin
      n_bad++; $display("FAIL unlock_green_solid: got %0d want 10", g);
    end
    n_cmp++;
    if (fails_left !== 4'd2 || locked !== 1'b0) begin
      n_bad++; $display("FAIL unlock_status: got fails=%0d locked=%0d want 2 0", fails_left, locked);
    end
  endtask

  task automatic test_wrong_digit();
    logic cs_mid;
    logic [15:0] cnts;
    int r;
    program_code(3, 1, 0, 2, 4, 4'h0, cs_mid);
    n_cmp++;
    if (cs_mid !== 1'b0 || code_set !== 1'b1) begin
      n_bad++; $display("FAIL reprogram_code_set: got mid=%0d end=%0d want 0 1", cs_mid, code_set);
    end
    enter_code(3, 1, 1, 2, cnts);
    n_cmp++;
    if (cnts !== 16'h4044) begin
      n_bad++; $display("FAIL wrong_digit_blink: got %h want 4044", cnts);
    end
    wait_neg(1);
    n_cmp++;
    if (fails_left !== 4'd1) begin
      n_bad++; $display("FAIL retry_fails_left: got %0d want 1", fails_left);
    end
    r = (led_red === 1'b1) ? 1 : 0;
    for (int k = 0; k < 7; k++) begin
      wait_neg(1);
      if (led_red === 1'b1) r++;
    end
    n_cmp++;
    if (r !== 4) begin
      n_bad++; $display("FAIL retry_red_blink: got %0d want 4", r);
    end
    wait_neg(1);
    n_cmp++;
    if (digit_idx !== 3'd0 || led_red !== 1'b0) begin
      n_bad++; $display("FAIL retry_exit: got idx=%0d red=%0d want 0 0", digit_idx, led_red);
    end
  endtask

  task automatic test_lockout();
    int exp_len [5];
    logic [15:0] cnts;
    int cnt, red;
    exp_len = '{32, 64, 128, 256, 256};
    for (int r = 0; r < 5; r++) begin
      if (r > 0) begin
        enter_code(3, 1, 1, 2, cnts);
        wait_neg(9);
      end
      enter_code(3, 1, 1, 2, cnts);
      cnt = 0; red = 0;
      while (locked === 1'b1 && cnt < 600) begin
        cnt++;
        wait_neg(1);
        if (led_red === 1'b1) red++;
      end
      $display("[tb] lockout round %0d: locked cycles=%0d red cycles=%0d", r, cnt, red);
      n_cmp++;
      if (cnt !== exp_len[r]) begin
        n_bad++; $display("FAIL lock_len_%0d: got %0d want %0d", r, cnt, exp_len[r]);
      end
      n_cmp++;
      if (red !== exp_len[r]) begin
        n_bad++; $display("FAIL lock_red_%0d: got %0d want %0d", r, red, exp_len[r]);
      end
      n_cmp++;
      if (fails_left !== 4'd2) begin
        n_bad++; $display("FAIL lock_reload_%0d: got %0d want 2", r, fails_left);
      end
      wait_neg(1);
      n_cmp++;
      if (led_red !== 1'b0) begin
        n_bad++; $display("FAIL lock_red_off_%0d: got %0d want 0", r, led_red);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] cnts;
    int c;
    enter_digit(3, c);
    enter_digit(1, c);
    wait_neg(58);
    n_cmp++;
    if (digit_idx !== 3'd2) begin
      n_bad++; $display("FAIL timeout_before: got idx=%0d want 2", digit_idx);
    end
    wait_neg(10);
    n_cmp++;
    if (digit_idx !== 3'd0 || fails_left !== 4'd2) begin
      n_bad++; $display("FAIL timeout_after: got idx=%0d fails=%0d want 0 2", digit_idx, fails_left);
    end
    $display("[tb] timeout: idx=%0d fails_left=%0d", digit_idx, fails_left);
    enter_code(3, 1, 0, 2, cnts);
    wait_neg(2);
    n_cmp++;
    if (cnts !== 16'h4444 || led_green !== 1'b1) begin
      n_bad++; $display("FAIL timeout_then_unlock: got counts=%h green=%0d want 4444 1", cnts, led_green);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    logic cs_mid;
    logic [11:0] cnts;
    logic [10:0] exp_v;
    int c;
    program_code(1, 1, 0, 2, 4, 4'b0100, cs_mid);
    n_cmp++;
    if (code_set !== 1'b1) begin
      n_bad++; $display("FAIL simul_code_set: got %0d want 1", code_set);
    end
    enter_digit(1, c); cnts[3:0]  = 4'(c);
    enter_digit(1, c); cnts[7:4]  = 4'(c);
    enter_digit(0, c); cnts[11:8] = 4'(c);
    $display("[tb] simultaneous press entry: green counts=%h", cnts);
    n_cmp++;
    if (cnts !== 12'h444) begin
      n_bad++; $display("FAIL simul_lowest_wins: got %h want 444", cnts);
    end
    btn_n[2] = 1'b0;
    wait_neg(2);
    btn_n = 4'hF;
    wait_neg(4);
    n_cmp++;
    if (digit_idx !== 3'd3) begin
      n_bad++; $display("FAIL pre_reset_idx: got %0d want 3", digit_idx);
    end
    rst = 1'b1;
    #2;
    exp_v = {1'b0, 1'b0, 3'd0, 4'd2, 1'b0, 1'b0};
    n_cmp++;
    if ({led_green, led_red, digit_idx, fails_left, locked, code_set} !== exp_v) begin
      n_bad++;
      $display("FAIL mid_feedback_reset: got %h want %h", {led_green, led_red, digit_idx, fails_left, locked, code_set}, exp_v);
    end
    wait_neg(2);
    rst = 1'b0;
    wait_neg(3);
    enter_digit(1, c);
    n_cmp++;
    if (c !== 0 || code_set !== 1'b0 || digit_idx !== 3'd0) begin
      n_bad++; $display("FAIL post_reset_code_lost: got green=%0d code_set=%0d idx=%0d want 0 0 0", c, code_set, digit_idx);
    end
    $display("[tb] reset mid-feedback: code_set=%0d fails_left=%0d", code_set, fails_left);
  endtask

  initial begin
    rst = 1'b1;
    confirm = 1'b0;
    btn_n = 4'hF;
    test_reset();
    test_program_short();
    test_program_full();
    test_unlock();
    test_wrong_digit();
    test_lockout();
    test_timeout();
    test_simultaneous_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
